// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM load bridge.
//   gat_state_e : bridge FSM state, also reported in status[ST_W-1:0]
//   STATUS_*    : status word layout {err_mask, done_mask, state}, LSB-aligned
package gat_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } gat_state_e;

   localparam int STATUS_STATE_LSB = 0;
   localparam int STATUS_DONE_LSB  = ST_W;

   // err_mask sits directly above the per-channel done_mask
   function automatic int status_err_lsb(input int num_ch);
      return ST_W + num_ch;
   endfunction

endpackage

// File: rtl/gat_load_chan.sv
// One load channel of the GAT BRAM bridge.
// Checks the bus write (alignment, range, load window), forwards the narrowed
// word one cycle later, counts accepted words and reports done/err.
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous clear of counter, err flag and write strobe
//   open        : bridge is in IDLE or LOAD, writes may be accepted
//   len         : expected word count for this channel
//   sw_done     : software override, forces done
//   din/ena/wea/addra : AXI-BRAM controller port (byte address)
//   accept      : combinational, this cycle's write is taken
//   wr_en/wr_addr/wr_data : registered write to the core BRAM
//   done, err   : channel complete / sticky error
module gat_load_chan #(
   parameter int TOP_WIDTH = 32,
   parameter int ADDR_W    = 18,
   parameter int CH_DATA_W = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 open,
   input  logic [ADDR_W-1:0]    len,
   input  logic                 sw_done,
   input  logic [TOP_WIDTH-1:0] din,
   input  logic                 ena,
   input  logic                 wea,
   input  logic [ADDR_W+1:0]    addra,
   output logic                 accept,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [CH_DATA_W-1:0] wr_data,
   output logic                 done,
   output logic                 err
);

   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] word;
   logic              wr_req;

   assign word   = addra[ADDR_W+1:2];
   assign wr_req = ena & wea;
   // clear wins over a coincident write, so the write is neither forwarded nor flagged
   assign accept = wr_req & (addra[1:0] == 2'b00) & (word < len) & open & ~clear;
   assign done   = (cnt == len) | sw_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         err     <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (clear) begin
         cnt   <= '0;
         err   <= 1'b0;
         wr_en <= 1'b0;
      end else begin
         wr_en <= accept;
         if (accept) begin
            wr_addr <= word;
            wr_data <= din[CH_DATA_W-1:0];
            // rewrites still count; saturate so done stays an equality test
            if (cnt != len) cnt <= cnt + ADDR_W'(1);
         end
         if (wr_req && !accept) err <= 1'b1;
      end
   end

   generate
      if (TOP_WIDTH > CH_DATA_W) begin : g_narrow
         logic unused_din_hi;
         assign unused_din_hi = ^din[TOP_WIDTH-1:CH_DATA_W];
      end
   endgenerate

endmodule

// File: rtl/gat_bram_load_bridge.sv
// Multi-channel bridge between the AXI-BRAM controller ports and the GAT core.
// Loads NUM_CH channels, fires a one-cycle core_start once all are done,
// waits for a rising core_ready and then opens the feature read-back path.
//   clk, rst_n          : clock, async active-low reset
//   cfg_len             : per-channel word count, sampled while IDLE
//   cfg_clear           : return to IDLE, clear counters and flags
//   sw_load_done        : per-channel done override (level)
//   bus_din/ena/wea/addra : per-channel bus write ports (byte addressed)
//   core_wr_en/addr/data: registered per-channel core BRAM writes
//   core_start          : one-cycle start pulse
//   core_ready          : core done level
//   rd_addrb            : byte read address, core_rd_addr is its word address
//   core_rd_data        : feature BRAM data (1-cycle latency)
//   rd_dout             : registered read data, zero outside DONE
//   status              : {err_mask, done_mask, state}, zero-padded
module gat_bram_load_bridge
   import gat_pkg::*;
#(
   parameter int TOP_WIDTH = 32,
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 18,
   parameter int CH_DATA_W = 20,
   parameter int RD_ADDR_W = 16,
   parameter int RD_DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH*ADDR_W-1:0]      cfg_len,
   input  logic                          cfg_clear,
   input  logic [NUM_CH-1:0]             sw_load_done,
   input  logic [NUM_CH*TOP_WIDTH-1:0]   bus_din,
   input  logic [NUM_CH-1:0]             bus_ena,
   input  logic [NUM_CH-1:0]             bus_wea,
   input  logic [NUM_CH*(ADDR_W+2)-1:0]  bus_addra,
   output logic [NUM_CH-1:0]             core_wr_en,
   output logic [NUM_CH*ADDR_W-1:0]      core_wr_addr,
   output logic [NUM_CH*CH_DATA_W-1:0]   core_wr_data,
   output logic                          core_start,
   input  logic                          core_ready,
   input  logic [RD_ADDR_W+1:0]          rd_addrb,
   output logic [RD_ADDR_W-1:0]          core_rd_addr,
   input  logic [RD_DATA_W-1:0]          core_rd_data,
   output logic [RD_DATA_W-1:0]          rd_dout,
   output logic [TOP_WIDTH-1:0]          status
);

   gat_state_e                state, state_nxt;
   logic [NUM_CH*ADDR_W-1:0] len_q;
   logic [NUM_CH*ADDR_W-1:0] len_eff;
   logic [NUM_CH-1:0]        accept;
   logic [NUM_CH-1:0]        done_mask;
   logic [NUM_CH-1:0]        err_mask;
   logic                     load_open;
   logic                     ready_q;
   logic [RD_DATA_W-1:0]     rd_q;

   assign load_open = (state == ST_IDLE) || (state == ST_LOAD);
   // IDLE follows cfg_len live; from LOAD on the value latched on leaving IDLE is used
   assign len_eff   = (state == ST_IDLE) ? cfg_len : len_q;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         gat_load_chan #(
            .TOP_WIDTH (TOP_WIDTH),
            .ADDR_W    (ADDR_W),
            .CH_DATA_W (CH_DATA_W)
         ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (cfg_clear),
            .open    (load_open),
            .len     (len_eff[g*ADDR_W +: ADDR_W]),
            .sw_done (sw_load_done[g]),
            .din     (bus_din[g*TOP_WIDTH +: TOP_WIDTH]),
            .ena     (bus_ena[g]),
            .wea     (bus_wea[g]),
            .addra   (bus_addra[g*(ADDR_W+2) +: (ADDR_W+2)]),
            .accept  (accept[g]),
            .wr_en   (core_wr_en[g]),
            .wr_addr (core_wr_addr[g*ADDR_W +: ADDR_W]),
            .wr_data (core_wr_data[g*CH_DATA_W +: CH_DATA_W]),
            .done    (done_mask[g]),
            .err     (err_mask[g])
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if ((|accept) || (|sw_load_done)) state_nxt = ST_LOAD;
         ST_LOAD:  if (&done_mask) state_nxt = ST_START;
         ST_START: state_nxt = ST_RUN;
         // registered edge detect: a level already high on entry must drop first
         ST_RUN:   if (core_ready && !ready_q) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (cfg_clear) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         len_q   <= '0;
         ready_q <= 1'b0;
         rd_q    <= '0;
      end else begin
         state   <= state_nxt;
         ready_q <= core_ready;
         rd_q    <= core_rd_data;
         if (state == ST_IDLE) len_q <= cfg_len;
      end
   end

   assign core_start   = (state == ST_START);
   assign core_rd_addr = rd_addrb[RD_ADDR_W+1:2];
   // gate at the output so stale data never leaks after a clear
   assign rd_dout      = (state == ST_DONE) ? rd_q : '0;
   assign status       = TOP_WIDTH'({err_mask, done_mask, state});

   logic unused_rd_lsb;
   assign unused_rd_lsb = ^rd_addrb[1:0];

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
module tb_gat_bram_load_bridge;

   localparam int TOP_WIDTH = 32;
   localparam int NUM_CH    = 4;
   localparam int ADDR_W    = 18;
   localparam int CH_DATA_W = 20;
   localparam int RD_ADDR_W = 16;
   localparam int RD_DATA_W = 32;
   localparam int AW2       = ADDR_W + 2;

   logic                         clk;
   logic                         rst_n;
   logic [NUM_CH*ADDR_W-1:0]     cfg_len;
   logic                         cfg_clear;
   logic [NUM_CH-1:0]            sw_load_done;
   logic [NUM_CH*TOP_WIDTH-1:0]  bus_din;
   logic [NUM_CH-1:0]            bus_ena;
   logic [NUM_CH-1:0]            bus_wea;
   logic [NUM_CH*AW2-1:0]        bus_addra;
   logic [NUM_CH-1:0]            core_wr_en;
   logic [NUM_CH*ADDR_W-1:0]     core_wr_addr;
   logic [NUM_CH*CH_DATA_W-1:0]  core_wr_data;
   logic                         core_start;
   logic                         core_ready;
   logic [RD_ADDR_W+1:0]         rd_addrb;
   logic [RD_ADDR_W-1:0]         core_rd_addr;
   logic [RD_DATA_W-1:0]         core_rd_data;
   logic [RD_DATA_W-1:0]         rd_dout;
   logic [TOP_WIDTH-1:0]         status;

   gat_bram_load_bridge #(
      .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W),
      .CH_DATA_W(CH_DATA_W), .RD_ADDR_W(RD_ADDR_W), .RD_DATA_W(RD_DATA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_clear(cfg_clear),
      .sw_load_done(sw_load_done), .bus_din(bus_din), .bus_ena(bus_ena),
      .bus_wea(bus_wea), .bus_addra(bus_addra), .core_wr_en(core_wr_en),
      .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
      .core_start(core_start), .core_ready(core_ready), .rd_addrb(rd_addrb),
      .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
      .rd_dout(rd_dout), .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // feature BRAM: fixed contents, one cycle of read latency
   function automatic logic [31:0] bram(input logic [15:0] a);
      return (a == 16'd4) ? 32'hCAFE0001 : {16'hBEEF, a};
   endfunction
   always @(posedge clk) core_rd_data <= bram(core_rd_addr);

   int n_chk = 0;
   int n_fail = 0;
   int n_start = 0;

   // reference model; states numbered as in the status field: 0 IDLE .. 4 DONE
   int          m_st;
   int          m_cnt [NUM_CH];
   int          m_len [NUM_CH];
   bit          m_err [NUM_CH];
   bit          m_wen [NUM_CH];
   int          m_wad [NUM_CH];
   int          m_wdt [NUM_CH];
   bit          m_rdy;
   logic [31:0] m_bq, m_rq;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int f_len(input int c);
      return int'(cfg_len[c*ADDR_W +: ADDR_W]);
   endfunction

   task automatic set_len(input int c, input int v);
      cfg_len[c*ADDR_W +: ADDR_W] = ADDR_W'(v);
   endtask

   task automatic set_wr(input int c, input bit en, input bit we, input int addr, input logic [31:0] d);
      bus_ena[c] = en;
      bus_wea[c] = we;
      bus_addra[c*AW2 +: AW2] = AW2'(addr);
      bus_din[c*TOP_WIDTH +: TOP_WIDTH] = d;
   endtask

   task automatic idle_bus();
      bus_ena = '0;
      bus_wea = '0;
      cfg_clear = 1'b0;
   endtask

   task automatic model_reset();
      m_st = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = 0; m_len[c] = 0; m_err[c] = 0;
         m_wen[c] = 0; m_wad[c] = 0; m_wdt[c] = 0;
      end
      m_rdy = 0;
      m_rq  = '0;
      m_bq  = core_rd_data;
   endtask

   task automatic compare_all();
      logic [NUM_CH-1:0] e_en, e_done, e_err;
      int lp;
      for (int c = 0; c < NUM_CH; c++) begin
         lp = (m_st == 0) ? f_len(c) : m_len[c];
         e_en[c]   = m_wen[c];
         e_done[c] = (m_cnt[c] == lp) || sw_load_done[c];
         e_err[c]  = m_err[c];
      end
      check("core_wr_en", core_wr_en, e_en);
      for (int c = 0; c < NUM_CH; c++)
         if (m_wen[c]) begin
            check("core_wr_addr", core_wr_addr[c*ADDR_W +: ADDR_W], m_wad[c]);
            check("core_wr_data", core_wr_data[c*CH_DATA_W +: CH_DATA_W], m_wdt[c]);
         end
      check("core_start", core_start, m_st == 2);
      check("status", status, {21'b0, e_err, e_done, 3'(m_st)});
      check("rd_dout", rd_dout, (m_st == 4) ? m_rq : 32'h0);
      check("core_rd_addr", core_rd_addr, rd_addrb[RD_ADDR_W+1:2]);
   endtask

   // advance one clock: step the model on the inputs seen at the edge, then compare
   task automatic tick();
      int lenE [NUM_CH];
      bit okv [NUM_CH];
      bit wr, any_ok, all_done;
      int a, n_st;
      any_ok = 0;
      all_done = 1;
      for (int c = 0; c < NUM_CH; c++) begin
         lenE[c] = (m_st == 0) ? f_len(c) : m_len[c];
         a  = int'(bus_addra[c*AW2 +: AW2]);
         wr = bus_ena[c] && bus_wea[c];
         okv[c] = wr && (a % 4 == 0) && ((a / 4) < lenE[c]) && (m_st <= 1) && !cfg_clear;
         if (okv[c]) any_ok = 1;
         if (!((m_cnt[c] == lenE[c]) || sw_load_done[c])) all_done = 0;
      end
      n_st = m_st;
      case (m_st)
         0: if (any_ok || (sw_load_done != 0)) n_st = 1;
         1: if (all_done) n_st = 2;
         2: n_st = 3;
         3: if (core_ready && !m_rdy) n_st = 4;
         default: n_st = m_st;
      endcase
      if (cfg_clear) n_st = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         a  = int'(bus_addra[c*AW2 +: AW2]);
         wr = bus_ena[c] && bus_wea[c];
         if (m_st == 0) m_len[c] = f_len(c);
         if (cfg_clear) begin
            m_cnt[c] = 0; m_err[c] = 0; m_wen[c] = 0;
         end else begin
            m_wen[c] = okv[c];
            if (okv[c]) begin
               m_wad[c] = a / 4;
               m_wdt[c] = int'(bus_din[c*TOP_WIDTH +: TOP_WIDTH] & 32'h000F_FFFF);
               if (m_cnt[c] < lenE[c]) m_cnt[c]++;
            end
            if (wr && !okv[c]) m_err[c] = 1;
         end
      end
      m_rq  = m_bq;
      m_bq  = bram(rd_addrb[RD_ADDR_W+1:2]);
      m_rdy = core_ready;
      m_st  = n_st;
      @(posedge clk);
      #1;
      compare_all();
      if (core_start) n_start++;
   endtask

   task automatic do_clear();
      cfg_clear = 1'b1;
      tick();
      cfg_clear = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_wr_en"}, core_wr_en, 0);
      check({tag, "_start"}, core_start, 0);
      check({tag, "_status"}, status, 0);
      check({tag, "_rd_dout"}, rd_dout, 0);
   endtask

   typedef struct {
      int len;
      bit ena;
      bit wea;
      int addr;
      bit exp_en;
      bit exp_err;
      int exp_st;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{4, 1, 1,  0, 1, 0, 1};
      vecs[1] = '{4, 1, 1, 12, 1, 0, 1};
      vecs[2] = '{4, 1, 1, 16, 0, 1, 0};
      vecs[3] = '{4, 1, 1,  5, 0, 1, 0};
      vecs[4] = '{4, 1, 1,  2, 0, 1, 0};
      vecs[5] = '{4, 1, 0,  0, 0, 0, 0};
      vecs[6] = '{4, 0, 1,  0, 0, 0, 0};
      vecs[7] = '{0, 1, 1,  0, 0, 1, 0};
      vecs[8] = '{1, 1, 1,  0, 1, 0, 1};
      vecs[9] = '{1, 1, 1,  4, 0, 1, 0};

      rst_n = 1'b0;
      cfg_clear = 1'b0;
      sw_load_done = '0;
      bus_din = '0;
      bus_ena = '0;
      bus_wea = '0;
      bus_addra = '0;
      core_ready = 1'b0;
      rd_addrb = '0;
      for (int c = 0; c < NUM_CH; c++) set_len(c, 4);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      model_reset();
      tick();

      // accept rule, one row per vector on channel 0
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < NUM_CH; c++) set_len(c, 4);
         set_len(0, vecs[i].len);
         do_clear();
         set_wr(0, vecs[i].ena, vecs[i].wea, vecs[i].addr, 32'h1234_5678 + i);
         tick();
         check("vec_wr_en", core_wr_en[0], vecs[i].exp_en);
         check("vec_err", status[7], vecs[i].exp_err);
         check("vec_state", status[2:0], vecs[i].exp_st);
         idle_bus();
      end

      // full in-order load, start timing, then read-back
      set_len(0, 8); set_len(1, 4); set_len(2, 16); set_len(3, 2);
      do_clear();
      n_start = 0;
      for (int k = 0; k < 16; k++) begin
         for (int c = 0; c < NUM_CH; c++)
            set_wr(c, k < f_len(c), k < f_len(c), k * 4, $urandom);
         tick();
      end
      idle_bus();
      check("t1_last_write", core_wr_en, 4'b0100);
      tick();
      check("t1_start_pulse", core_start, 1);
      check("t1_state_start", status[2:0], 2);
      check("t1_done_mask", status[6:3], 4'hF);
      tick();
      check("t1_start_drop", core_start, 0);
      check("t1_state_run", status[2:0], 3);
      rd_addrb = 18'h10;
      tick(); tick();
      check("t4_rd_in_run", rd_dout, 0);
      core_ready = 1'b1;
      tick();
      check("t4_state_done", status[2:0], 4);
      rd_addrb = 18'h0;
      tick();
      rd_addrb = 18'h10;
      tick(); tick();
      check("t4_rd_dout", rd_dout, 32'hCAFE0001);
      check("t1_start_count", n_start, 1);
      core_ready = 1'b0;

      // misaligned and out-of-range writes on channel 0
      for (int c = 0; c < NUM_CH; c++) set_len(c, 8);
      do_clear();
      set_wr(0, 1, 1, 6, 32'hAAAA_AAAA);
      tick();
      set_wr(0, 1, 1, 32, 32'hBBBB_BBBB);
      tick();
      idle_bus();
      check("t2_wr_en", core_wr_en, 0);
      check("t2_err_mask", status[10:7], 4'b0001);
      check("t2_done_mask", status[6:3], 0);

      // channel 2 overridden by software; core_ready already high on RUN entry
      for (int c = 0; c < NUM_CH; c++) set_len(c, 2);
      do_clear();
      sw_load_done = 4'b0100;
      core_ready = 1'b1;
      n_start = 0;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NUM_CH; c++) set_wr(c, c != 2, c != 2, k * 4, $urandom);
         tick();
      end
      idle_bus();
      repeat (6) tick();
      check("t3_start_count", n_start, 1);
      check("t3_hold_run", status[2:0], 3);
      core_ready = 1'b0;
      tick();
      core_ready = 1'b1;
      tick();
      check("t3_rise_done", status[2:0], 4);
      sw_load_done = '0;
      core_ready = 1'b0;

      // clear coincident with a valid write in LOAD
      for (int c = 0; c < NUM_CH; c++) set_len(c, 4);
      do_clear();
      set_wr(0, 1, 1, 0, 32'h1);
      tick();
      set_wr(0, 1, 1, 4, 32'h2);
      cfg_clear = 1'b1;
      tick();
      idle_bus();
      check("t5_wr_dropped", core_wr_en, 0);
      check("t5_status", status, 0);

      // async reset mid-load loses partial counts
      for (int c = 0; c < NUM_CH; c++) set_len(c, 2);
      do_clear();
      set_wr(0, 1, 1, 0, 32'h10); tick();
      set_wr(0, 1, 1, 4, 32'h11); tick();
      idle_bus();
      set_wr(1, 1, 1, 0, 32'h12); tick();
      idle_bus();
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("t6_async");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      n_start = 0;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NUM_CH; c++) set_wr(c, c != 0, c != 0, k * 4, $urandom);
         tick();
      end
      idle_bus();
      repeat (3) tick();
      check("t6_no_start", n_start, 0);
      check("t6_ch0_not_done", status[3], 0);
      for (int k = 0; k < 2; k++) begin
         set_wr(0, 1, 1, k * 4, $urandom);
         tick();
      end
      idle_bus();
      repeat (3) tick();
      check("t6_start_after_reload", n_start, 1);

      // randomized episodes against the model
      for (int ep = 0; ep < 40; ep++) begin
         idle_bus();
         sw_load_done = '0;
         core_ready = 1'b0;
         do_clear();
         for (int c = 0; c < NUM_CH; c++) set_len(c, $urandom_range(0, 5));
         for (int cy = 0; cy < 60; cy++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               int r;
               r = $urandom_range(0, 9);
               if (r < 6)       set_wr(c, 1, 1, 4 * $urandom_range(0, f_len(c)), $urandom);
               else if (r == 6) set_wr(c, 1, 1, 4 * $urandom_range(0, 5) + $urandom_range(1, 3), $urandom);
               else if (r == 7) set_wr(c, 1, 0, 0, $urandom);
               else             set_wr(c, 0, 0, 0, $urandom);
            end
            if ($urandom_range(0, 19) == 0) sw_load_done = 4'($urandom);
            if ($urandom_range(0, 3) == 0) core_ready = ~core_ready;
            rd_addrb = 18'($urandom_range(0, 15) * 4 + (($urandom_range(0, 7) == 0) ? 1 : 0));
            cfg_clear = ($urandom_range(0, 99) == 0);
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
